// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_W_MIN = 4;
  localparam int DIV_W_MAX = 64;

  // Magnitude of a width-bit two's complement value, returned one bit wider
  // so that the most negative value maps to an exact positive magnitude.
  function automatic logic [DIV_W_MAX:0] abs_ext(input logic [DIV_W_MAX-1:0] value,
                                                 input int width);
    logic [DIV_W_MAX-1:0] upper;
    logic [DIV_W_MAX-1:0] ext;
    logic [DIV_W_MAX-1:0] mag;
    logic                 sign;
    upper = ~((64'd1 << width) - 64'd1);
    sign  = |((value >> (width - 1)) & 64'd1);
    ext   = sign ? (value | upper) : (value & ~upper);
    mag   = ext[DIV_W_MAX-1] ? -ext : ext;
    return {1'b0, mag};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           msb,
  input  logic [WIDTH:0] bmag,
  output logic [WIDTH:0] rem_out,
  output logic           qbit
);

  logic [WIDTH+1:0] shifted;

  // Partial remainder never reaches 2^WIDTH, so the truncated difference is exact.
  always_comb begin
    shifted = {rem_in, msb};
    qbit    = (shifted >= {1'b0, bmag});
    rem_out = qbit ? (WIDTH+1)'(shifted - {1'b0, bmag}) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring radix-2 on magnitudes, sign fix-up last.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// CALC  | one quotient bit per cycle, count runs WIDTH-1 down to 0
// FIX   | apply signs, load q/r/div_by_zero
// DONE  | done pulse; new start accepted exactly as in IDLE
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < DIV_W_MIN || WIDTH > DIV_W_MAX) begin : g_bad_width
    $error("seq_signed_divider: WIDTH outside supported range");
  end

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   bmag;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic             sa;
  logic             sb;
  logic             bz;
  logic [WIDTH:0]   rem_nxt;
  logic             qbit;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .msb     (dvd[WIDTH-1]),
    .bmag    (bmag),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == '0) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up; a zero divisor forces the all-ones quotient while r falls out as a.
  always_comb begin
    fix_q = (sa ^ sb) ? -quo : quo;
    if (bz) fix_q = {WIDTH{1'b1}};
    fix_r = WIDTH'(sa ? -rem : rem);
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      dvd         <= '0;
      bmag        <= '0;
      rem         <= '0;
      quo         <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      bz          <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count <= CNT_W'(WIDTH - 1);
      dvd   <= WIDTH'(abs_ext(64'(a), WIDTH));
      bmag  <= (WIDTH+1)'(abs_ext(64'(b), WIDTH));
      rem   <= '0;
      quo   <= '0;
      sa    <= a[WIDTH-1];
      sb    <= b[WIDTH-1];
      bz    <= (b == '0);
    end else if (state == CALC) begin
      rem <= rem_nxt;
      quo <= {quo[WIDTH-2:0], qbit};
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      if (count != '0) count <= count - CNT_W'(1);
    end else if (state == FIX) begin
      q           <= fix_q;
      r           <= fix_r;
      div_by_zero <= bz;
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider at WIDTH=32 and WIDTH=8.
module tb_seq_signed_divider;

  localparam int W  = 32;
  localparam int W8 = 8;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dz;
  logic [31:0] q, r;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  int   n_chk = 0;
  int   n_err = 0;
  int   edge_n = 0;
  int   bc32 = 0, bc8 = 0;
  int   n_done32 = 0;
  exp_t sb32[$];
  exp_t sb8[$];

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(dz)
  );

  seq_signed_divider #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .div_by_zero(dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input longint av, input longint bv, input int due);
    exp_t   e;
    longint qq, rr;
    if (bv == 0) begin
      qq = -1; rr = av; e.dz = 1'b1;
    end else begin
      qq = av / bv; rr = av % bv; e.dz = 1'b0;
    end
    e.q = 32'(qq); e.r = 32'(rr); e.due = due;
    return e;
  endfunction

  // 32-bit result monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bc32 = 0;
    end else begin
      if (busy) bc32++;
      if (done) begin
        n_done32++;
        chk("sb32_entry", sb32.size() > 0, 1);
        if (sb32.size() > 0) begin
          e = sb32.pop_front();
          chk("q32", q, e.q);
          chk("r32", r, e.r);
          chk("dz32", dz, e.dz);
          chk("lat32", edge_n, e.due);
          chk("busy_cycles32", bc32, W + 1);
        end
        bc32 = 0;
      end
    end
  end

  // 8-bit result monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bc8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        chk("sb8_entry", sb8.size() > 0, 1);
        if (sb8.size() > 0) begin
          e = sb8.pop_front();
          chk("q8", q8, e.q[7:0]);
          chk("r8", r8, e.r[7:0]);
          chk("dz8", dz8, e.dz);
          chk("lat8", edge_n, e.due);
          chk("busy_cycles8", bc8, W8 + 1);
        end
        bc8 = 0;
      end
    end
  end

  // Callers are positioned just after a rising edge with the DUT able to accept.
  task automatic issue32(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    a = av; b = bv; start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.due = edge_n + W + 2;
    sb32.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue32_model(input logic [31:0] av, input logic [31:0] bv);
    exp_t m;
    m = model(longint'($signed(av)), longint'($signed(bv)), 0);
    issue32(av, bv, m.q, m.r, m.dz);
  endtask

  task automatic wait_done32();
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("done32_seen", done, 1);
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    a8 = av; b8 = bv; start8 = 1'b1;
    e = model(longint'($signed(av)), longint'($signed(bv)), edge_n + W8 + 2);
    sb8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("done8_seen", done8, 1);
  endtask

  initial begin
    int          saved_done;
    int          n;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;

    // Reset with a coincident start request that must be dropped.
    rst = 1'b1; start = 1'b1; a = 32'd50; b = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", dz, 0);
    @(posedge clk); #1;
    chk("start_with_rst_dropped", busy, 0);

    // Basic and sign matrix, issued back to back in DONE cycles.
    issue32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done32();
    issue32(-32'd100, 32'd7, -32'd14, -32'd2, 1'b0);
    wait_done32();
    issue32(32'd100, -32'd7, -32'd14, 32'd2, 1'b0);
    wait_done32();
    issue32(-32'd100, -32'd7, 32'd14, -32'd2, 1'b0);
    wait_done32();

    // Most negative dividend and divide by zero.
    issue32(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    wait_done32();
    issue32(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    wait_done32();
    issue32(-32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    wait_done32();
    issue32(32'd0, -32'd9, 32'd0, 32'd0, 1'b0);
    wait_done32();

    // Back-to-back with start pulses while busy.
    issue32(32'd9, 32'd2, 32'd4, 32'd1, 1'b0);
    wait_done32();
    issue32(32'd20, 32'd3, 32'd6, 32'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    a = 32'd123; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("q_hold_while_busy", q, 32'd4);
    repeat (10) @(posedge clk);
    #1;
    a = -32'd77; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done32();

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    saved_done = n_done32;
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_dz", dz, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("abort_no_done", n_done32, saved_done);

    // Random 32-bit operands, with small and zero divisors mixed in.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($signed($urandom_range(0, 30)) - 15);
        1:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      issue32_model(ra, rb);
      wait_done32();
    end

    // 8-bit instance: corners then random pairs.
    @(posedge clk); #1;
    issue8(8'h80, 8'hFF); wait_done8();
    issue8(8'h80, 8'h01); wait_done8();
    issue8(8'hFB, 8'h00); wait_done8();
    issue8(8'h00, 8'h05); wait_done8();
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom);
      rb8 = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      issue8(ra8, rb8);
      wait_done8();
    end

    n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    chk("sb32_drained", sb32.size(), 0);
    chk("sb8_drained", sb8.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
